// File: rtl/iig_stream_gen.sv
// Streaming integral-image generator: raster pixels in, one {ii, sq} BRAM word per pixel out.
// Two-stage pipeline: stage 1 captures the accepted pixel, stage 2 accumulates and writes.
module iig_stream_gen #(
  parameter int unsigned IMG_W  = 80,
  parameter int unsigned IMG_H  = 60,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned II_W   = 21,
  parameter int unsigned SQ_EN  = 1,
  parameter int unsigned SQ_W   = 32,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iRun,
  input  logic              iValid,
  output logic              oReady,
  input  logic [PIX_W-1:0]  iData,
  output logic              oWrreq,
  output logic [ADDR_W-1:0] oAddr,
  output logic [II_W-1:0]   oData_ii,
  output logic [SQ_W-1:0]   oData_sq,
  output logic              oBusy,
  output logic              oFrame_done
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              v1_q, v1_d;
  logic [PIX_W-1:0]  p1_q, p1_d;
  logic [XW-1:0]     x1_q, x1_d;
  logic              row0_1_q, row0_1_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic              last1_q, last1_d;

  logic [II_W-1:0]   rs_q, rs_d;
  logic [SQ_W-1:0]   rq_q, rq_d;

  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic [II_W-1:0]   ii_q, ii_d;
  logic [SQ_W-1:0]   sq_q, sq_d;
  logic              done_q, done_d;

  logic [II_W-1:0]   lb_ii_q [IMG_W];
  logic [SQ_W-1:0]   lb_sq_q [IMG_W];

  logic              accept;
  logic              last_px;
  logic [SQ_W-1:0]   p_ext;
  logic [II_W-1:0]   rs_sum, ii_sum;
  logic [SQ_W-1:0]   rq_sum, sq_sum;

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    x_d      = x_q;
    y_d      = y_q;
    addr_d   = addr_q;
    v1_d     = 1'b0;
    p1_d     = p1_q;
    x1_d     = x1_q;
    row0_1_d = row0_1_q;
    addr1_d  = addr1_q;
    last1_d  = 1'b0;
    rs_d     = rs_q;
    rq_d     = rq_q;
    wr_d     = 1'b0;
    oaddr_d  = oaddr_q;
    ii_d     = ii_q;
    sq_d     = sq_q;
    done_d   = 1'b0;

    accept  = iValid & ready_q;
    last_px = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

    // Busy drops after the final write unless a new frame has already started
    if (done_q && (state_q == S_IDLE)) busy_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
        if (iRun) begin
          state_d = S_RUN;
          ready_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (accept) begin
          x_d    = x_q + XW'(1);
          addr_d = addr_q + ADDR_W'(1);
          if (x_q == XW'(IMG_W - 1)) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end
          if (last_px) begin
            state_d = S_IDLE;
            ready_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
      end
    endcase

    // Stage 1: capture the accepted pixel with its coordinates
    if (accept) begin
      v1_d     = 1'b1;
      p1_d     = iData;
      x1_d     = x_q;
      row0_1_d = (y_q == '0);
      addr1_d  = addr_q;
      last1_d  = last_px;
    end

    // Stage 2: row sums plus the previous row's integral from the line buffer
    p_ext  = SQ_W'(p1_q);
    rs_sum = ((x1_q == '0) ? II_W'(0) : rs_q) + II_W'(p1_q);
    ii_sum = rs_sum + (row0_1_q ? II_W'(0) : lb_ii_q[x1_q]);
    rq_sum = ((x1_q == '0) ? SQ_W'(0) : rq_q) + (p_ext * p_ext);
    sq_sum = rq_sum + (row0_1_q ? SQ_W'(0) : lb_sq_q[x1_q]);
    if (SQ_EN == 0) begin
      rq_sum = '0;
      sq_sum = '0;
    end

    if (v1_q) begin
      rs_d    = rs_sum;
      rq_d    = rq_sum;
      wr_d    = 1'b1;
      oaddr_d = addr1_q;
      ii_d    = ii_sum;
      sq_d    = sq_sum;
      done_d  = last1_q;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      v1_q     <= 1'b0;
      p1_q     <= '0;
      x1_q     <= '0;
      row0_1_q <= 1'b0;
      addr1_q  <= '0;
      last1_q  <= 1'b0;
      rs_q     <= '0;
      rq_q     <= '0;
      wr_q     <= 1'b0;
      oaddr_q  <= '0;
      ii_q     <= '0;
      sq_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
      v1_q     <= v1_d;
      p1_q     <= p1_d;
      x1_q     <= x1_d;
      row0_1_q <= row0_1_d;
      addr1_q  <= addr1_d;
      last1_q  <= last1_d;
      rs_q     <= rs_d;
      rq_q     <= rq_d;
      wr_q     <= wr_d;
      oaddr_q  <= oaddr_d;
      ii_q     <= ii_d;
      sq_q     <= sq_d;
      done_q   <= done_d;
    end
  end

  // Line buffer needs no reset: row 0 never reads it
  always_ff @(posedge iClk) begin
    if (v1_q) begin
      lb_ii_q[x1_q] <= ii_sum;
      lb_sq_q[x1_q] <= sq_sum;
    end
  end

  assign oReady      = ready_q;
  assign oWrreq      = wr_q;
  assign oAddr       = oaddr_q;
  assign oData_ii    = ii_q;
  assign oData_sq    = sq_q;
  assign oBusy       = busy_q;
  assign oFrame_done = done_q;

endmodule
